nibble_serial_adder: RTL

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

---
 rtl/nibble_add_pkg.sv | 14 +
 rtl/add4.sv | 16 +
 rtl/nibble_serial_adder.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/nibble_add_pkg.sv
// nibble_add_pkg
//   Shared definitions for the nibble-serial adder: digit width and the
//   controller state encoding.
package nibble_add_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/add4.sv
// add4
//   Plain 4-bit unsigned adder with carry-out, no carry-in.
//   Ports:
//     a, b : 4-bit addends
//     s    : 4-bit sum
//     co   : carry-out
module add4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] s,
    output logic       co
);

    assign {co, s} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Adds two unsigned operands of NIBBLES 4-bit digits, one digit per clock,
//   least-significant digit first, with a valid/ready handshake on each side.
//
//   Optional feature: define NIBBLE_SERIAL_ADDER_OVF_EN to add the ovf output
//   (two's-complement overflow of the result).
//
//   Ports:
//     clk, rst_n           : clock, asynchronous active-low reset
//     in_valid / in_ready  : operand handshake (ready only in IDLE)
//     in_a, in_b, in_cin   : operands and carry-in, captured on accept
//     out_valid / out_ready: result handshake (valid only in DONE)
//     out_sum, out_cout    : result, held until the next operation completes
//     ovf                  : overflow flag (only with NIBBLE_SERIAL_ADDER_OVF_EN)
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for operands; in_ready=1
//   RUN   | one digit added per cycle; NIBBLES cycles
//   DONE  | result presented; out_valid=1 until out_ready
module nibble_serial_adder
    import nibble_add_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0] in_a,
    input  logic [NIBBLE_W*NIBBLES-1:0] in_b,
    input  logic                        in_cin,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0] out_sum,
    output logic                        out_cout
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    ,
    output logic                        ovf
`endif
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int CNT_W = $clog2(NIBBLES);
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NIBBLES - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // a_q doubles as the result register: each digit's sum enters the top
    // nibble that the right shift has just vacated.
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic               carry_q, carry_d;
    logic [W-1:0]       sum_q, sum_d;
    logic               cout_q, cout_d;

    logic [NIBBLE_W-1:0] s_ab;
    logic [NIBBLE_W-1:0] s_dig;
    logic                co_ab;
    logic                co_cin;
    logic                nib_co;

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    logic msb_a_q, msb_a_d;
    logic msb_b_q, msb_b_d;
    logic ovf_q, ovf_d;
`endif

    add4 u_add_ab (
        .a  (a_q[NIBBLE_W-1:0]),
        .b  (b_q[NIBBLE_W-1:0]),
        .s  (s_ab),
        .co (co_ab)
    );

    add4 u_add_cin (
        .a  (s_ab),
        .b  ({{(NIBBLE_W-1){1'b0}}, carry_q}),
        .s  (s_dig),
        .co (co_cin)
    );

    // The two stages can never both carry, so OR gives the digit carry.
    assign nib_co = co_ab | co_cin;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        msb_a_d = msb_a_q;
        msb_b_d = msb_b_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_cin;
                    cnt_d   = '0;
                    state_d = RUN;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
                    msb_a_d = in_a[W-1];
                    msb_b_d = in_b[W-1];
`endif
                end
            end
            RUN: begin
                a_d     = {s_dig, a_q[W-1:NIBBLE_W]};
                b_d     = {{NIBBLE_W{1'b0}}, b_q[W-1:NIBBLE_W]};
                carry_d = nib_co;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_DIGIT) begin
                    state_d = DONE;
                    sum_d   = {s_dig, a_q[W-1:NIBBLE_W]};
                    cout_d  = nib_co;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
                    ovf_d   = (msb_a_q == msb_b_q) &&
                              (s_dig[NIBBLE_W-1] != msb_a_q);
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            msb_a_q <= 1'b0;
            msb_b_q <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            msb_a_q <= msb_a_d;
            msb_b_q <= msb_b_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule
